// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V control sequencer with run/step, halt and retire count
//
// Purpose: drives the datapath enables/selects one phase per cycle (fetch,
// decode, execute, memory, write-back). Architectural writes (PC, register
// file, data memory) are only asserted in an instruction's final state.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   run        in   level, back-to-back execution
//   step       in   single-instruction start, sampled in IDLE only
//   opcode     in   IR[6:0]
//   funct3     in   IR[14:12]
//   aluZero    in   ALU zero flag
//   irWrite, pcWrite, pcSrc, regWrite, memRead, memWrite, memToReg,
//   aluSrc     out  datapath enables/selects
//   aluOp      out  00 add, 01 sub, 10 funct decode
//   instrDone  out  pulse in an instruction's final state
//   halted     out  high in HALT
//   state      out  current state encoding
//   retired    out  completed-instruction count (wraps)

module multicycle_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        aluZero,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        pcSrc,
    output logic        regWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        memToReg,
    output logic        aluSrc,
    output logic [1:0]  aluOp,
    output logic        instrDone,
    output logic        halted,
    output logic [3:0]  state,
    output logic [15:0] retired
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXECUTE   = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_HALT      = 4'd10;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [15:0] r_retired;
    logic        w_instr_done;
    logic        w_final_next;

    // Next instruction (or IDLE) after a final state depends only on run;
    // step is deliberately not consulted outside IDLE.
    assign w_final_next = run ? S_FETCH : S_IDLE;

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:      w_next = (run || step) ? S_FETCH : S_IDLE;
            S_FETCH:     w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:      w_next = S_MEM_ADDR;
                    OP_RTYPE, OP_ADDI: w_next = S_EXECUTE;
                    OP_BRANCH:         w_next = (funct3 == 3'b000 || funct3 == 3'b001)
                                                ? S_BRANCH : S_HALT;
                    default:           w_next = S_HALT;
                endcase
            end
            // Only lw and sw can reach MEM_ADDR, so anything not lw is sw.
            S_MEM_ADDR:  w_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next = S_MEM_WB;
            S_EXECUTE:   w_next = S_ALU_WB;
            S_MEM_WB,
            S_MEM_WRITE,
            S_ALU_WB,
            S_BRANCH:    w_next = w_final_next;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        pcSrc     = 1'b0;
        regWrite  = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        memToReg  = 1'b0;
        aluSrc    = 1'b0;
        aluOp     = 2'b00;
        instrDone = 1'b0;
        halted    = 1'b0;
        case (r_state)
            S_FETCH:     irWrite = 1'b1;
            S_MEM_ADDR:  aluSrc  = 1'b1;
            S_MEM_READ: begin
                aluSrc  = 1'b1;
                memRead = 1'b1;
            end
            S_MEM_WB: begin
                aluSrc    = 1'b1;
                memRead   = 1'b1;
                memToReg  = 1'b1;
                regWrite  = 1'b1;
                pcWrite   = 1'b1;
                instrDone = 1'b1;
            end
            S_MEM_WRITE: begin
                aluSrc    = 1'b1;
                memWrite  = 1'b1;
                pcWrite   = 1'b1;
                instrDone = 1'b1;
            end
            S_EXECUTE: begin
                aluSrc = (opcode == OP_ADDI);
                aluOp  = (opcode == OP_ADDI) ? 2'b00 : 2'b10;
            end
            S_ALU_WB: begin
                aluSrc    = (opcode == OP_ADDI);
                aluOp     = (opcode == OP_ADDI) ? 2'b00 : 2'b10;
                regWrite  = 1'b1;
                pcWrite   = 1'b1;
                instrDone = 1'b1;
            end
            S_BRANCH: begin
                aluOp     = 2'b01;
                pcWrite   = 1'b1;
                instrDone = 1'b1;
                // beq takes the target on zero, bne on non-zero.
                pcSrc     = (funct3 == 3'b000) ? aluZero : ~aluZero;
            end
            S_HALT:      halted = 1'b1;
            default: ;
        endcase
    end

    assign w_instr_done = instrDone;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_retired <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_instr_done) begin
                r_retired <= r_retired + 16'h0001;
            end
        end
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        aluZero = 1'b0;
    logic        irWrite, pcWrite, pcSrc, regWrite, memRead, memWrite, memToReg, aluSrc;
    logic [1:0]  aluOp;
    logic        instrDone, halted;
    logic [3:0]  state;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl dut (
        .clock(clock), .reset(reset), .run(run), .step(step),
        .opcode(opcode), .funct3(funct3), .aluZero(aluZero),
        .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .aluSrc(aluSrc),
        .aluOp(aluOp), .instrDone(instrDone), .halted(halted),
        .state(state), .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: instruction-level. Each instruction is a list of the
    // phases it walks through after FETCH; run/step only matter at the seams.
    int          m_cur = 0;
    int          m_q[$];
    logic [15:0] m_ret = 16'd0;
    int          sel_q[$];

    function automatic bit is_final(input int s);
        return (s == 5) || (s == 6) || (s == 8) || (s == 9);
    endfunction

    // {irWrite,pcWrite,pcSrc,regWrite,memRead,memWrite,memToReg,aluSrc,aluOp,instrDone,halted}
    function automatic logic [11:0] exp_out(input int s, input logic [6:0] op,
                                            input logic [2:0] f3, input logic z);
        logic addi;
        addi = (op == 7'b0010011);
        case (s)
            1:  return 12'b1000_0000_00_0_0;
            3:  return 12'b0000_0001_00_0_0;
            4:  return 12'b0000_1001_00_0_0;
            5:  return 12'b0101_1011_00_1_0;
            6:  return 12'b0100_0101_00_1_0;
            7:  return {7'b0000_000, addi, addi ? 2'b00 : 2'b10, 2'b00};
            8:  return {7'b0101_000, addi, addi ? 2'b00 : 2'b10, 2'b10};
            9:  return {2'b01, (f3 == 3'b000) ? z : ~z, 5'b0_0000, 2'b01, 2'b10};
            10: return 12'b0000_0000_00_0_1;
            default: return 12'd0;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        chk_eq({tag, ".state"}, {28'd0, state}, m_cur);
        chk_eq({tag, ".outs"}, {20'd0, irWrite, pcWrite, pcSrc, regWrite, memRead, memWrite,
                                memToReg, aluSrc, aluOp, instrDone, halted},
               {20'd0, exp_out(m_cur, opcode, funct3, aluZero)});
        chk_eq({tag, ".retired"}, {16'd0, retired}, {16'd0, m_ret});
    endtask

    // 0 lw, 1 sw, 2 R, 3 addi, 4 beq, 5 bne, 6 jal (illegal), 7 branch funct3>=010 (illegal)
    task automatic pick_instr();
        int sel;
        if (sel_q.size() > 0) sel = sel_q.pop_front();
        else if ($urandom_range(0, 99) < 3) sel = 6 + $urandom_range(0, 1);
        else sel = $urandom_range(0, 5);
        funct3 = 3'($urandom_range(0, 7));
        case (sel)
            0: begin opcode = 7'b0000011; m_q = '{2, 3, 4, 5}; end
            1: begin opcode = 7'b0100011; m_q = '{2, 3, 6}; end
            2: begin opcode = 7'b0110011; m_q = '{2, 7, 8}; end
            3: begin opcode = 7'b0010011; m_q = '{2, 7, 8}; end
            4: begin opcode = 7'b1100011; funct3 = 3'b000; m_q = '{2, 9}; end
            5: begin opcode = 7'b1100011; funct3 = 3'b001; m_q = '{2, 9}; end
            6: begin opcode = 7'b1101111; m_q = '{2, 10}; end
            default: begin
                opcode = 7'b1100011;
                funct3 = 3'($urandom_range(2, 7));
                m_q = '{2, 10};
            end
        endcase
    endtask

    // Called at a falling edge: check, drive the next inputs, advance the model.
    task automatic do_cycle(input string tag, input logic r, input logic s, input logic z);
        int nxt;
        check_outputs(tag);
        run = r;
        step = s;
        aluZero = z;
        if (m_cur == 1) pick_instr();
        if (m_cur == 10) nxt = 10;
        else if (m_q.size() > 0) nxt = m_q.pop_front();
        else nxt = (r || (m_cur == 0 && s)) ? 1 : 0;
        if (is_final(m_cur)) m_ret = m_ret + 16'd1;
        @(negedge clock);
        m_cur = nxt;
    endtask

    // Called at a falling edge; reset takes effect without waiting for a clock.
    task automatic do_reset(input string tag);
        run = 1'b0;
        step = 1'b0;
        reset = 1'b1;
        #1;
        m_cur = 0;
        m_ret = 16'd0;
        m_q.delete();
        check_outputs(tag);
        #1;
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int guard;
        @(negedge clock);
        @(negedge clock);
        check_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        // single step of an addi: 0,1,2,7,8,0
        sel_q = '{3};
        do_cycle("step0", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) do_cycle("step", 1'b0, 1'b0, 1'b0);
        chk_eq("step.idle_after", {28'd0, state}, 32'd0);
        chk_eq("step.retired", {16'd0, retired}, 32'd1);

        // lw, sw, add back to back: 1 IDLE cycle + 13 cycles
        do_reset("rst1");
        sel_q = '{0, 1, 2};
        for (int i = 0; i < 14; i++) do_cycle("lsa", 1'b1, 1'b0, 1'b0);
        chk_eq("lsa.retired13", {16'd0, retired}, 32'd3);

        // branches with both aluZero values
        sel_q = '{4, 5, 4, 5};
        for (int i = 0; i < 8; i++) do_cycle("br_z1", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) do_cycle("br_z0", 1'b1, 1'b0, 1'b0);

        // illegal opcodes halt; run/step then have no effect
        for (int k = 6; k <= 7; k++) begin
            do_reset("rst_h");
            sel_q = '{k};
            for (int i = 0; i < 4; i++) do_cycle("halt_in", 1'b1, 1'b0, 1'b0);
            chk_eq("halt.state", {28'd0, state}, 32'd10);
            for (int i = 0; i < 6; i++)
                do_cycle("halt_toggle", 1'($urandom), 1'($urandom), 1'($urandom));
            do_reset("halt_rst");
            chk_eq("halt.cleared", {31'd0, halted}, 32'd0);
        end

        // reset while in MEM_READ abandons the lw
        sel_q = '{0};
        guard = 0;
        while (m_cur != 4 && guard < 20) begin
            do_cycle("to_memrd", 1'b1, 1'b0, 1'b0);
            guard++;
        end
        chk_eq("memrd.reached", m_cur, 32'd4);
        do_reset("memrd_rst");
        for (int i = 0; i < 3; i++) do_cycle("post_rst", 1'b0, 1'b0, 1'b0);

        // counter wrap: preload near the top, retire two addi
        force dut.r_retired = 16'hFFFE;
        #1;
        release dut.r_retired;
        m_ret = 16'hFFFE;
        @(negedge clock);
        sel_q = '{3, 3};
        for (int i = 0; i < 5; i++) do_cycle("wrap", 1'b1, 1'b0, 1'b0);
        chk_eq("wrap.ffff", {16'd0, retired}, 32'h0000FFFF);
        for (int i = 0; i < 3; i++) do_cycle("wrap", 1'b1, 1'b0, 1'b0);
        do_cycle("wrap", 1'b0, 1'b0, 1'b0);
        chk_eq("wrap.zero", {16'd0, retired}, 32'd0);

        // random run/step/aluZero with occasional resets
        guard = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0 || (m_cur == 10 && guard > 5)) begin
                do_reset("rnd_rst");
                guard = 0;
            end else begin
                if (m_cur == 10) guard++;
                do_cycle("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                         1'($urandom));
            end
        end
        check_outputs("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control sequencer that runs the RISC-V datapath in multicycle mode: fetch, decode, execute, memory and write-back each get their own cycle, and PC, register-file and data-memory writes happen only in an instruction's final state. It sits between the instruction register and the datapath muxes/enables, in place of the single-cycle control decoder. It adds run/single-step control for the FPGA debug path, a halt on unsupported opcodes, and a retired-instruction counter.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears the counter
- run  in  1  level; while high, instructions execute back-to-back
- step  in  1  sampled only in IDLE; high starts exactly one instruction
- opcode  in  7  IR[6:0]; stable from DECODE until the instruction ends
- funct3  in  3  IR[14:12]; stable from DECODE until the instruction ends
- aluZero  in  1  ALU zero flag
- irWrite  out  1  load the instruction register
- pcWrite  out  1  load PC this cycle
- pcSrc  out  1  0 = PC+4, 1 = PC+imm (branch target)
- regWrite, memRead, memWrite, memToReg, aluSrc  out  1 each  datapath enables/selects, same meaning as the single-cycle control signals
- aluOp  out  2  00 = add, 01 = sub, 10 = decode funct3/funct7
- instrDone  out  1  one-cycle pulse in an instruction's final state
- halted  out  1  high in HALT
- state  out  4  current state encoding (debug)
- retired  out  16  count of completed instructions

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, HALT=10. Codes 11–15 go to IDLE on the next edge.
- IDLE → FETCH when run | step; otherwise stay in IDLE.
- FETCH → DECODE unconditionally.
- DECODE transitions by opcode:
  - 0000011 (lw) → MEM_ADDR
  - 0100011 (sw) → MEM_ADDR
  - 0110011 (R-type) → EXECUTE
  - 0010011 (addi) → EXECUTE
  - 1100011 (branch) with funct3 ∈ {000, 001} → BRANCH
  - anything else → HALT
- MEM_ADDR → MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ → MEM_WB.
- EXECUTE → ALU_WB.
- Final states (MEM_WB, MEM_WRITE, ALU_WB, BRANCH) → FETCH if run, else IDLE.
- HALT is absorbing; only reset leaves it.
- Outputs are a function of state only. Any signal not listed for a state is 0.
  - FETCH: irWrite.
  - MEM_ADDR: aluSrc.
  - MEM_READ: aluSrc, memRead.
  - MEM_WB: aluSrc, memRead, memToReg, regWrite, pcWrite, instrDone.
  - MEM_WRITE: aluSrc, memWrite, pcWrite, instrDone.
  - EXECUTE and ALU_WB:
    - aluSrc = (opcode == 0010011).
    - aluOp = 10 for R-type, 00 for addi.
    - ALU_WB additionally asserts regWrite, pcWrite, instrDone.
  - BRANCH:
    - aluOp = 01, pcWrite, instrDone.
    - pcSrc = (funct3 == 000) ? aluZero : ~aluZero.
  - HALT: halted.
- pcSrc is 0 in every state except BRANCH.
- retired: +1 on each edge where instrDone = 1; unsigned 16-bit, wraps 0xFFFF → 0x0000.

## Timing
- Reset (asynchronous, takes effect immediately): state = IDLE, retired = 0, every other output = 0.
- Reset mid-instruction: the instruction is abandoned. No regWrite, memWrite or pcWrite occurs after reset asserts. The first FETCH is on the first edge after reset release with run | step high.
- Latency in cycles, counted from FETCH up to and including the final state:
  - lw: 5
  - sw: 4
  - R-type / addi: 4
  - branch: 3
- From IDLE with run high: FETCH is entered on the next edge.
- With run held high: the final state is followed directly by FETCH, with no IDLE cycle.
- run dropping mid-instruction: the current instruction completes, then the sequencer goes to IDLE.
- step:
  - Level-sampled in IDLE only; ignored in every other state, including HALT.
  - Held high for N cycles, it restarts from each IDLE it reaches.
  - run and step high together behave the same as run alone.
- Write timing: writes land on the edge that leaves the final state. PC changes only on that edge; IR changes only on the FETCH exit edge.

## Test plan
- Reset with run=0, then step pulsed for 1 cycle with an addi opcode → state sequence 0,1,2,7,8,0; instrDone high only in state 8; retired = 1; pcWrite=1, pcSrc=0 in state 8.
- run=1, program lw, sw, add → lw takes 5 cycles, sw and add take 4 each, with no IDLE between them; memRead high only in states 4–5, memWrite only in state 6, memToReg only in state 5; retired = 3 after 13 cycles.
- Branch, with the ALU returning aluZero=1:
  - funct3 = 000 → pcSrc=1 in state 9.
  - funct3 = 001 → pcSrc=0.
  - Repeat with aluZero=0 → pcSrc is the inverse in each case.
- Opcode 1101111, or a branch with funct3 = 100 → HALT (state 10), halted=1, no pcWrite; run/step toggling has no effect; reset → IDLE, halted=0.
- Reset asserted asynchronously while in MEM_READ → all outputs 0 and state 0 in the same cycle, with no memWrite/regWrite pulse; retired = 0.
- Preload 0xFFFE retired instructions (via run) then complete 2 more → retired reads 0xFFFF, then 0x0000.
